pipe_stage_buf: RTL and testbench

//  Elastic pipeline-stage register. Generalises the fixed MEM/WB latch into one

---
 rtl/pipe_stage_buf.sv | 60 ++++++
 tb/tb_pipe_stage_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline register backed by a DEPTH-entry circular buffer.
// Flush or reset empties the buffer so o_data shows the FLUSH_VAL bubble.
module pipe_stage_buf #(
    parameter int DATA_W = 105,
    parameter int DEPTH = 2,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CW-1:0]     o_count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, never on i_ready.
    always_comb begin
        o_ready = count_q < CW'(DEPTH);
        o_valid = count_q != '0;
        o_count = count_q;
        o_data  = o_valid ? mem_q[rd_ptr_q] : FLUSH_VAL;
        push    = i_valid & o_ready;
        pop     = o_valid & i_ready;
    end

    always_comb begin
        mem_d = mem_q;
        if (push && !i_flush) mem_d[wr_ptr_q] = i_data;
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (!i_rst_n || i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and scoreboarded checks of pipe_stage_buf at DEPTH 1, 2 and 3.
module tb_pipe_stage_buf;
    localparam logic [15:0] FV2 = 16'hF1F1;

    logic i_clk = 1'b0;
    logic rst_n, flush;
    int checks = 0, errors = 0;

    logic         v1, r1, ov1, or1;
    logic [104:0] d1, od1;
    logic [0:0]   oc1;
    logic         v2, r2, ov2, or2;
    logic [15:0]  d2, od2;
    logic [1:0]   oc2;
    logic         v3, r3, ov3, or3;
    logic [15:0]  d3, od3;
    logic [1:0]   oc3;

    always #5 i_clk = ~i_clk;

    pipe_stage_buf #(.DATA_W(105), .DEPTH(1)) u1 (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v1), .o_ready(or1),
        .i_data(d1), .o_valid(ov1), .i_ready(r1), .o_data(od1), .o_count(oc1));
    pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .FLUSH_VAL(FV2)) u2 (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v2), .o_ready(or2),
        .i_data(d2), .o_valid(ov2), .i_ready(r2), .o_data(od2), .o_count(oc2));
    pipe_stage_buf #(.DATA_W(16), .DEPTH(3)) u3 (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v3), .o_ready(or3),
        .i_data(d3), .o_valid(ov3), .i_ready(r3), .o_data(od3), .o_count(oc3));

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({ov2, or2, oc2, od2} !== {1'b0, 1'b1, 2'd0, FV2}) begin
            errors++;
            $display("FAIL reset_d2 got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=%h", ov2, or2, oc2, od2, FV2);
        end
        checks++;
        if ({ov1, or1, oc1, od1} !== {1'b0, 1'b1, 1'b0, 105'd0}) begin
            errors++;
            $display("FAIL reset_d1 got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0", ov1, or1, oc1, od1);
        end
        checks++;
        if ({ov3, or3, oc3, od3} !== {1'b0, 1'b1, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_d3 got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0", ov3, or3, oc3, od3);
        end
    endtask

    task automatic test_stream();
        logic [15:0] vec [3] = '{16'h00A1, 16'h00B2, 16'h00C3};
        r2 = 1'b1;
        v2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d2 = vec[i];
            step();
            checks++;
            if ({ov2, oc2, od2} !== {1'b1, 2'd1, vec[i]}) begin
                errors++;
                $display("FAIL stream_%0d got v=%b c=%0d d=%h want v=1 c=1 d=%h", i, ov2, oc2, od2, vec[i]);
            end
        end
        v2 = 1'b0;
        step();
        checks++;
        if ({ov2, oc2, od2} !== {1'b0, 2'd0, FV2}) begin
            errors++;
            $display("FAIL stream_drain got v=%b c=%0d d=%h want v=0 c=0 d=%h", ov2, oc2, od2, FV2);
        end
    endtask

    task automatic test_backpressure();
        r2 = 1'b0;
        v2 = 1'b1;
        d2 = 16'h0A0A;
        step();
        d2 = 16'h0B0B;
        step();
        checks++;
        if ({oc2, or2, od2} !== {2'd2, 1'b0, 16'h0A0A}) begin
            errors++;
            $display("FAIL bp_full got c=%0d r=%b d=%h want c=2 r=0 d=0a0a", oc2, or2, od2);
        end
        d2 = 16'h0C0C;
        step();
        checks++;
        if ({oc2, or2, od2} !== {2'd2, 1'b0, 16'h0A0A}) begin
            errors++;
            $display("FAIL bp_hold got c=%0d r=%b d=%h want c=2 r=0 d=0a0a", oc2, or2, od2);
        end
        r2 = 1'b1;
        step();
        checks++;
        if ({oc2, or2, od2} !== {2'd1, 1'b1, 16'h0B0B}) begin
            errors++;
            $display("FAIL bp_popA got c=%0d r=%b d=%h want c=1 r=1 d=0b0b", oc2, or2, od2);
        end
        step();
        checks++;
        if ({oc2, ov2, od2} !== {2'd1, 1'b1, 16'h0C0C}) begin
            errors++;
            $display("FAIL bp_popB got c=%0d v=%b d=%h want c=1 v=1 d=0c0c", oc2, ov2, od2);
        end
        v2 = 1'b0;
        step();
        checks++;
        if ({oc2, ov2} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_drain got c=%0d v=%b want c=0 v=0", oc2, ov2);
        end
    endtask

    task automatic test_flush_full();
        r2 = 1'b0;
        v2 = 1'b1;
        d2 = 16'h1111;
        step();
        d2 = 16'h2222;
        step();
        checks++;
        if (oc2 !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre got c=%0d want c=2", oc2);
        end
        flush = 1'b1;
        r2 = 1'b1;
        d2 = 16'h3333;
        step();
        flush = 1'b0;
        v2 = 1'b0;
        checks++;
        if ({oc2, ov2, or2, od2} !== {2'd0, 1'b0, 1'b1, FV2}) begin
            errors++;
            $display("FAIL flush_full got c=%0d v=%b r=%b d=%h want c=0 v=0 r=1 d=%h", oc2, ov2, or2, od2, FV2);
        end
        step();
        checks++;
        if ({oc2, ov2} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_lost got c=%0d v=%b want c=0 v=0", oc2, ov2);
        end
        v2 = 1'b1;
        d2 = 16'h4444;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        v2 = 1'b0;
        checks++;
        if ({oc2, od2} !== {2'd0, FV2}) begin
            errors++;
            $display("FAIL flush_mid got c=%0d d=%h want c=0 d=%h", oc2, od2, FV2);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] q[$];
        logic [15:0] exp_d;
        logic pu, po;
        v3 = 1'b1;
        r3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d3 = 16'h0100 + 16'(i);
            step();
            checks++;
            if ({oc3, od3} !== {2'd1, 16'h0100 + 16'(i)}) begin
                errors++;
                $display("FAIL wrap_pair_%0d got c=%0d d=%h want c=1 d=%h", i, oc3, od3, 16'h0100 + 16'(i));
            end
        end
        v3 = 1'b0;
        step();
        for (int i = 0; i < 200; i++) begin
            v3 = 1'($urandom_range(0, 1));
            r3 = ($urandom_range(0, 3) != 0) ? (i % 40 < 25) : 1'b0;
            d3 = 16'($urandom);
            pu = v3 && (q.size() < 3);
            po = r3 && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(d3);
            step();
            exp_d = (q.size() > 0) ? q[0] : 16'd0;
            checks++;
            if ({oc3, or3, ov3, od3} !== {2'(q.size()), q.size() < 3, q.size() > 0, exp_d}) begin
                errors++;
                $display("FAIL wrap_rand_%0d got c=%0d r=%b v=%b d=%h want c=%0d d=%h", i, oc3, or3, ov3, od3, q.size(), exp_d);
            end
        end
        v3 = 1'b0;
        r3 = 1'b0;
    endtask

    task automatic test_depth1();
        int cnt = 0, pushed = 0, popped = 0;
        logic [104:0] held = '0;
        v1 = 1'b1;
        r1 = 1'b1;
        d1 = 105'h1_0000_0000_0000_0000_0000_0001;
        for (int i = 0; i < 8; i++) begin
            if (cnt == 0) begin
                held = d1;
                cnt = 1;
                pushed++;
            end else begin
                cnt = 0;
                popped++;
            end
            step();
            if (cnt == 1) d1 = d1 + 105'd3;
            checks++;
            if ({ov1, or1, od1} !== {cnt == 1, cnt == 0, (cnt == 1) ? held : 105'd0}) begin
                errors++;
                $display("FAIL depth1_%0d got v=%b r=%b d=%h want v=%0d d=%h", i, ov1, or1, od1, cnt, held);
            end
        end
        v1 = 1'b0;
        checks++;
        if (pushed != popped) begin
            errors++;
            $display("FAIL depth1_balance got pushed=%0d popped=%0d want equal", pushed, popped);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        {v1, r1, v2, r2, v3, r3} = '0;
        d1 = '0;
        d2 = '0;
        d3 = '0;
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_wrap();
        test_depth1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
